encode_64b66b_cl49: RTL
=======================

Name: encode_64b66b_cl49

Overview:
- Parametrised Clause-49 64b/66b transmit encoder. Sits between the XGMII-side MAC interface and the GTX TX gearbox.
- Encodes every legal XGMII column into its proper block type: C, O, S0, S4, T0..T7 and D.
- Runs the 802.3 transmit state machine and replaces illegal sequences with /E/ blocks.
- Optionally accepts 32-bit XGMII half-columns and optionally scrambles the payload.

Parameters:
- INPUT_W, 64: XGMII data width, 64 or 32. In 32-bit mode two valid beats form one column, lanes 0-3 first.
- SCRAMBLE_EN, 0: 1 enables the x^58+x^39+1 payload scrambler.
- ERR_CNT_W, 16: width of the saturating error counter.

Ports:
- clk_i  in  1  encoder clock
- rst_n_i  in  1  asynchronous reset, active low
- xgmii_txd_i  in  INPUT_W  XGMII data; lane 0 = [7:0]
- xgmii_txc_i  in  INPUT_W/8  XGMII control flags; 1 = control char
- xgmii_txd_vld_i  in  1  beat valid
- err_cnt_clr_i  in  1  synchronous clear of err_cnt_o
- encode_data_o  out  64  block payload, type byte at [7:0]
- encode_head_o  out  2  sync header: 2'b10 data, 2'b01 control
- encode_data_vld_o  out  1  block valid, one cycle per block
- encode_error_o  out  1  one-cycle pulse, aligned with an /E/ block caused by an illegal sequence
- err_cnt_o  out  ERR_CNT_W  saturating count of encode_error_o pulses

Behaviour:
- Reset is asynchronous and active low; one clock. Reset values:
  - outputs: data 0, head 0, vld 0, error 0, err_cnt 0
  - internal: state TX_INIT, 32-bit phase 0, scrambler state all ones
- Beat valid low: no state, phase or scrambler advance; vld 0; data and head hold.
- Column classification (64-bit column, control chars I=0x07, S=0xFB, T=0xFD, E=0xFE, Q=0x9C):
  - D: txc=0x00.
  - S0: txc=0x01, lane0=S.
  - S4: txc=0x1F, lanes0-3 = I, lane4 = S.
  - C: txc=0xFF, all lanes I; or O-column: txc=0xF1, lane0=Q, lanes4-7 = I.
  - Tk: txc equals ~((1<<k)-1) over 8 bits, lane k = T, lanes above k = I.
  - E: anything else, including any E char.
- Block formats (7-bit control code: I→0x00, E→0x1E):
  - C: type 0x1E, C0..C7 at [14:8]..[63:57].
  - O: type 0x4B, D1..D3 at [31:8], O-code 0 at [35:32], C4..C7 at [63:36].
  - S0: type 0x78, lanes1-7 at [63:8].
  - S4: type 0x33, C0..C3 at [35:8], 0 at [39:36], lanes5-7 at [63:40].
  - Tk: type 0x87/99/AA/B4/CC/D2/E1/FF for k=0..7; D0..D(k-1) at [8k+7:8]; then (7-k) zero bits; then C(k+1)..C7.
  - D: head 10, payload = column.
  - All other blocks: head 01.
  - E block: type 0x1E, all eight codes 0x1E.
- State machine (states TX_INIT, TX_C, TX_D, TX_E):
  - TX_INIT or TX_C:
    - C → TX_C, emit C.
    - S → TX_D, emit S.
    - otherwise → TX_E, emit E with error pulse.
  - TX_D:
    - D → stay, emit D.
    - T → TX_C, emit T.
    - otherwise → TX_E, emit E with error pulse.
  - TX_E (recovers on any legal class):
    - C → TX_C; D → TX_D; T → TX_C; S → TX_D; each emits its own block.
    - E → stay, emit E with error pulse.
- Latency, beat valid to encode_data_vld_o:
  - SCRAMBLE_EN=0: 1 cycle.
  - SCRAMBLE_EN=1: 2 cycles, with a registered scrambler stage.
  - In 32-bit mode, latency is counted from the second beat. A first beat produces no output.
- 32-bit phase toggles per valid beat; wraps 1→0.
- Scrambler:
  - Applied to the 64 payload bits, bit 0 first; the header is never scrambled.
  - Advances only on emitted blocks.
- err_cnt_o:
  - +1 per error pulse, saturates at all ones.
  - Clear has priority over increment; clear and error in the same cycle → 1.

Decomposition:
- Package enc66_pkg holds:
  - XGMII char constants, 7-bit code constants, block type constants, sync header constants.
  - State enum and column-class enum.
- Sub-module scrambler_64b66b holds the registered 58-bit LFSR with enable.

Test Plan (SCRAMBLE_EN=0, INPUT_W=64 unless stated):
- Idle column: txd 0x0707070707070707, txc 0xFF → head 01, data 0x000000000000001E, error 0.
- Frame: S0 0xD5555555555555FB/0x01 → data 0xD555555555555578; then D 0x1122334455667788/0x00 → head 10, same data; then T3 0x07070707FD030201/0xF8 → 0x00000000030201B4; state returns to TX_C.
- S4: txd 0xD55555FB07070707, txc 0x1F after idles → 0xD555550000000033, head 01.
- Illegal: D column while in TX_C → E block (type 0x1E, codes all 0x1E), encode_error_o for 1 cycle, err_cnt_o=1. A following idle column → C block with no error.
- Counter: ERR_CNT_W=2, five errors → err_cnt_o holds 3. Clear together with an error → 1.
- INPUT_W=32: two beats 0x07070707/0xF → one idle block, vld 1 cycle after the 2nd beat. A single beat then rst_n_i low → no output, phase 0.
- SCRAMBLE_EN=1: scrambled payload matches the LFSR reference model from the all-ones seed; latency 2.

Source files
------------

// File: rtl/enc66_pkg.sv
// Shared constants, enums and block payload type for the Clause-49 64b/66b
// transmit encoder.
package enc66_pkg;

  localparam int unsigned COL_W   = 64;
  localparam int unsigned SCR_W   = 58;
  localparam int unsigned SCR_TAP = 39;

  // XGMII control characters
  localparam logic [7:0] CH_I = 8'h07;
  localparam logic [7:0] CH_S = 8'hFB;
  localparam logic [7:0] CH_T = 8'hFD;
  localparam logic [7:0] CH_Q = 8'h9C;

  // 7-bit block control codes
  localparam logic [6:0] CC_I = 7'h00;
  localparam logic [6:0] CC_E = 7'h1E;

  // Block type bytes
  localparam logic [7:0] BT_C  = 8'h1E;
  localparam logic [7:0] BT_O  = 8'h4B;
  localparam logic [7:0] BT_S0 = 8'h78;
  localparam logic [7:0] BT_S4 = 8'h33;

  localparam logic [1:0] SH_DATA = 2'b10;
  localparam logic [1:0] SH_CTRL = 2'b01;

  localparam logic [COL_W-1:0] E_BLOCK = {{8{CC_E}}, BT_C};

  typedef enum logic [1:0] {TX_INIT, TX_C, TX_D, TX_E} tx_state_e;
  typedef enum logic [2:0] {CLS_C, CLS_S, CLS_T, CLS_D, CLS_E} col_class_e;

  typedef struct packed {
    logic [1:0]       head;
    logic [COL_W-1:0] data;
  } blk_t;

  // Type byte of a terminate block whose /T/ sits in lane k
  function automatic logic [7:0] term_type(input logic [2:0] k);
    case (k)
      3'd0:    return 8'h87;
      3'd1:    return 8'h99;
      3'd2:    return 8'hAA;
      3'd3:    return 8'hB4;
      3'd4:    return 8'hCC;
      3'd5:    return 8'hD2;
      3'd6:    return 8'hE1;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/encode_64b66b_scrambler.sv
// Self-synchronous x^58+x^39+1 payload scrambler; state and output advance
// only when a block is presented.
module scrambler_64b66b
  import enc66_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en,
  input  logic [COL_W-1:0] din,
  output logic [COL_W-1:0] dout
);

  logic [SCR_W-1:0] st_q;
  logic [SCR_W-1:0] st_d;
  logic [COL_W-1:0] sd;

  // st_d[0] is the most recent scrambled bit; bit 0 of the payload goes first
  always_comb begin
    st_d = st_q;
    sd   = '0;
    for (int i = 0; i < int'(COL_W); i++) begin
      sd[i] = din[i] ^ st_d[SCR_TAP-1] ^ st_d[SCR_W-1];
      st_d  = {st_d[SCR_W-2:0], sd[i]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st_q <= '1;
      dout <= '0;
    end else if (en) begin
      st_q <= st_d;
      dout <= sd;
    end
  end

endmodule

// File: rtl/encode_64b66b_cl49.sv
// Clause-49 64b/66b transmit encoder: column classification, transmit state
// machine with /E/ substitution, optional 32-bit input and scrambling.
module encode_64b66b_cl49 #(
  parameter int unsigned INPUT_W     = 64,
  parameter int unsigned SCRAMBLE_EN = 0,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [INPUT_W-1:0]     xgmii_txd_i,
  input  logic [INPUT_W/8-1:0]   xgmii_txc_i,
  input  logic                   xgmii_txd_vld_i,
  input  logic                   err_cnt_clr_i,
  output logic [63:0]            encode_data_o,
  output logic [1:0]             encode_head_o,
  output logic                   encode_data_vld_o,
  output logic                   encode_error_o,
  output logic [ERR_CNT_W-1:0]   err_cnt_o
);
  import enc66_pkg::*;

  logic [COL_W-1:0] col_d;
  logic [7:0]       col_c;
  logic             col_vld;
  logic [7:0]       idle_l;
  col_class_e       cls;
  blk_t             blk;
  blk_t             emit;
  logic [7:0]       t_mask;
  logic [7:0]       t_hi;
  logic [COL_W-1:0] t_dat;
  tx_state_e        state_q;
  tx_state_e        state_d;
  logic             emit_err;
  logic             out_ld;
  logic             out_err;
  logic [1:0]       out_head;

  // Column assembly: 32-bit beats pair up, lanes 0-3 first
  if (INPUT_W == 32) begin : g_half
    logic        phase_q;
    logic [31:0] lo_d_q;
    logic [3:0]  lo_c_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        phase_q <= 1'b0;
        lo_d_q  <= '0;
        lo_c_q  <= '0;
      end else if (xgmii_txd_vld_i) begin
        phase_q <= ~phase_q;
        if (!phase_q) begin
          lo_d_q <= xgmii_txd_i;
          lo_c_q <= xgmii_txc_i;
        end
      end
    end

    assign col_d   = {xgmii_txd_i, lo_d_q};
    assign col_c   = {xgmii_txc_i, lo_c_q};
    assign col_vld = xgmii_txd_vld_i & phase_q;
  end else begin : g_full
    assign col_d   = 64'(xgmii_txd_i);
    assign col_c   = 8'(xgmii_txc_i);
    assign col_vld = xgmii_txd_vld_i;
  end

  always_comb begin
    for (int i = 0; i < 8; i++) idle_l[i] = (col_d[8*i +: 8] == CH_I);
  end

  // Classify the column and build the block it would legally encode to
  always_comb begin
    cls    = CLS_E;
    blk    = '{head: SH_CTRL, data: E_BLOCK};
    t_mask = '0;
    t_hi   = '0;
    t_dat  = '0;
    if (col_c == 8'h00) begin
      cls = CLS_D;
      blk = '{head: SH_DATA, data: col_d};
    end else if (col_c == 8'h01 && col_d[7:0] == CH_S) begin
      cls = CLS_S;
      blk.data = {col_d[63:8], BT_S0};
    end else if (col_c == 8'h1F && (&idle_l[3:0]) && col_d[39:32] == CH_S) begin
      cls = CLS_S;
      blk.data = {col_d[63:40], 4'h0, {4{CC_I}}, BT_S4};
    end else if (col_c == 8'hFF && (&idle_l)) begin
      cls = CLS_C;
      blk.data = {{8{CC_I}}, BT_C};
    end else if (col_c == 8'hF1 && col_d[7:0] == CH_Q && (&idle_l[7:4])) begin
      cls = CLS_C;
      blk.data = {{4{CC_I}}, 4'h0, col_d[31:8], BT_O};
    end else begin
      for (int k = 0; k < 8; k++) begin
        t_mask = 8'hFF << k;
        t_hi   = t_mask << 1;
        if (col_c == t_mask && col_d[8*k +: 8] == CH_T && (&(idle_l | ~t_hi))) begin
          cls      = CLS_T;
          t_dat    = col_d & ~({COL_W{1'b1}} << (8*k));
          blk.data = {t_dat[55:0], term_type(3'(k))};
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= TX_INIT;
    else          state_q <= state_d;
  end

  // Transmit state machine; illegal sequences become /E/ blocks
  always_comb begin
    state_d  = state_q;
    emit_err = 1'b0;
    if (col_vld) begin
      unique case (state_q)
        TX_INIT, TX_C: begin
          if (cls == CLS_C)      state_d = TX_C;
          else if (cls == CLS_S) state_d = TX_D;
          else begin
            state_d  = TX_E;
            emit_err = 1'b1;
          end
        end
        TX_D: begin
          if (cls == CLS_D)      state_d = TX_D;
          else if (cls == CLS_T) state_d = TX_C;
          else begin
            state_d  = TX_E;
            emit_err = 1'b1;
          end
        end
        TX_E: begin
          case (cls)
            CLS_C, CLS_T: state_d = TX_C;
            CLS_D, CLS_S: state_d = TX_D;
            default: begin
              state_d  = TX_E;
              emit_err = 1'b1;
            end
          endcase
        end
      endcase
    end
    emit = emit_err ? '{head: SH_CTRL, data: E_BLOCK} : blk;
  end

  if (SCRAMBLE_EN != 0) begin : g_scr
    logic             s1_vld_q;
    logic             s1_err_q;
    logic [1:0]       s1_head_q;
    logic [COL_W-1:0] s1_data_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        s1_vld_q  <= 1'b0;
        s1_err_q  <= 1'b0;
        s1_head_q <= '0;
        s1_data_q <= '0;
      end else begin
        s1_vld_q <= col_vld;
        s1_err_q <= emit_err;
        if (col_vld) begin
          s1_head_q <= emit.head;
          s1_data_q <= emit.data;
        end
      end
    end

    scrambler_64b66b u_scr (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en      (s1_vld_q),
      .din     (s1_data_q),
      .dout    (encode_data_o)
    );

    assign out_ld   = s1_vld_q;
    assign out_head = s1_head_q;
    assign out_err  = s1_vld_q & s1_err_q;
  end else begin : g_byp
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)     encode_data_o <= '0;
      else if (col_vld) encode_data_o <= emit.data;
    end

    assign out_ld   = col_vld;
    assign out_head = emit.head;
    assign out_err  = emit_err;
  end

  // Output flags and saturating error counter; clear wins over increment
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      encode_head_o     <= '0;
      encode_data_vld_o <= 1'b0;
      encode_error_o    <= 1'b0;
      err_cnt_o         <= '0;
    end else begin
      encode_data_vld_o <= out_ld;
      encode_error_o    <= out_err;
      if (out_ld) encode_head_o <= out_head;
      if (err_cnt_clr_i)
        err_cnt_o <= ERR_CNT_W'(out_err);
      else if (out_err && err_cnt_o != {ERR_CNT_W{1'b1}})
        err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
    end
  end

endmodule
